// File: rtl/matrix_adder_arbiter_if.sv
// Request/grant/done bundle between the matrix-adder arbiter (slave side)
// and the client fabric plus adder (master side).
interface matrix_adder_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int COUNT_WIDTH    = 16
);
  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] request_vector;
  logic [NUM_REQUESTERS-1:0] grant_vector;
  logic [IDX_W-1:0]          grant_index;
  logic [NUM_REQUESTERS-1:0] done_vector;
  logic                      adder_start;
  logic                      adder_complete;
  logic                      busy;
  logic                      timeout_error;
  logic [COUNT_WIDTH-1:0]    completed_op_count;

  modport master (
    output request_vector, adder_complete,
    input  grant_vector, grant_index, done_vector, adder_start,
           busy, timeout_error, completed_op_count
  );

  modport slave (
    input  request_vector, adder_complete,
    output grant_vector, grant_index, done_vector, adder_start,
           busy, timeout_error, completed_op_count
  );
endinterface

// File: rtl/matrix_adder_arbiter.sv
// Round-robin sequencer sharing one matrix adder among several clients:
// grant, start pulse, wait for completion (with watchdog), done pulse.
module matrix_adder_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                  clock_signal,
  input  logic                  reset_signal,
  matrix_adder_arbiter_if.slave arb_bus
);
  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQUESTERS-1:0] ONE_HOT0 = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          rr_ptr;
  logic [WD_W-1:0]           watchdog;
  logic [NUM_REQUESTERS-1:0] grant_vector;
  logic [IDX_W-1:0]          grant_index;
  logic [NUM_REQUESTERS-1:0] done_vector;
  logic                      adder_start;
  logic                      busy;
  logic                      timeout_error;
  logic [COUNT_WIDTH-1:0]    completed_op_count;
  logic [IDX_W:0]            pick;

  // Returns {valid, index} of the first request found searching upward from
  // ptr+1 with wrap; scanning downward lets the nearest candidate win last.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQUESTERS-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   result;
    logic [IDX_W-1:0] cand;
    result = '0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQUESTERS);
      if (req[cand]) result = {1'b1, cand};
    end
    return result;
  endfunction

  always_comb pick = rr_pick(arb_bus.request_vector, rr_ptr);

  always_ff @(posedge clock_signal or posedge reset_signal) begin
    if (reset_signal) begin
      state              <= IDLE;
      rr_ptr             <= IDX_W'(NUM_REQUESTERS - 1);
      watchdog           <= '0;
      grant_vector       <= '0;
      grant_index        <= '0;
      done_vector        <= '0;
      adder_start        <= 1'b0;
      busy               <= 1'b0;
      timeout_error      <= 1'b0;
      completed_op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[IDX_W]) begin
            grant_vector <= ONE_HOT0 << pick[IDX_W-1:0];
            grant_index  <= pick[IDX_W-1:0];
            rr_ptr       <= pick[IDX_W-1:0];
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          adder_start <= 1'b1;
          watchdog    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          adder_start <= 1'b0;
          // Completion takes priority over a coincident watchdog expiry.
          if (arb_bus.adder_complete) begin
            done_vector <= grant_vector;
            state       <= RELEASE;
          end else if (watchdog == WD_LAST) begin
            done_vector   <= grant_vector;
            timeout_error <= 1'b1;
            state         <= RELEASE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RELEASE: begin
          if (!timeout_error) completed_op_count <= completed_op_count + 1'b1;
          done_vector   <= '0;
          timeout_error <= 1'b0;
          grant_vector  <= '0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_bus.grant_vector       = grant_vector;
  assign arb_bus.grant_index        = grant_index;
  assign arb_bus.done_vector        = done_vector;
  assign arb_bus.adder_start        = adder_start;
  assign arb_bus.busy               = busy;
  assign arb_bus.timeout_error      = timeout_error;
  assign arb_bus.completed_op_count = completed_op_count;
endmodule
